cp_mux_n_to_1_arb: RTL and testbench

Parametrised N-channel to 1 registered multiplexer with valid/ready handshake, successor to the 2:1 32-bit line mux. Selects one of NUM_CH input channels either by explicit select (fixed mode) or by round-robin arbitration. The selected word is captured into a single output register stage. Sits between multiple producers and a single downstream consumer on the datapath.

---
 rtl/cp_mux_n_to_1_arb.sv | 95 +++++++++
 tb/tb_cp_mux_n_to_1_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cp_mux_n_to_1_arb.sv
// N-channel to 1 registered multiplexer with valid/ready handshake.
// Channel chosen by explicit select (fixed mode) or round-robin arbitration.
module cp_mux_n_to_1_arb #(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned NUM_CH     = 4,
    localparam int unsigned SEL_W      = $clog2(NUM_CH)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_en,
    input  logic                         i_mode,
    input  logic [SEL_W-1:0]             i_sel,
    input  logic [NUM_CH-1:0]            i_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic [NUM_CH-1:0]            o_ready,
    output logic [DATA_WIDTH-1:0]        o_y,
    output logic [SEL_W-1:0]             o_ch,
    output logic                         o_valid,
    input  logic                         i_ready
);

    logic [SEL_W-1:0]      last_q;
    logic [SEL_W-1:0]      rr_idx;
    logic                  rr_vld;
    logic                  fix_vld;
    logic [SEL_W-1:0]      grant_idx;
    logic                  grant_vld;
    logic                  load_ok;
    logic                  load;
    logic [DATA_WIDTH-1:0] sel_data;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int unsigned idx;
        rr_vld = 1'b0;
        rr_idx = '0;
        idx    = 0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            idx = (32'(last_q) + off) % NUM_CH;
            if (!rr_vld && i_valid[SEL_W'(idx)]) begin
                rr_vld = 1'b1;
                rr_idx = SEL_W'(idx);
            end
        end
    end

    // Fixed select; an out-of-range index matches no channel and never grants.
    always_comb begin
        fix_vld = 1'b0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (i_sel == SEL_W'(k)) begin
                fix_vld = i_valid[k];
            end
        end
    end

    assign grant_idx = i_mode ? rr_idx : i_sel;
    assign grant_vld = i_mode ? rr_vld : fix_vld;
    assign load_ok   = i_rst_n & i_en & (~o_valid | i_ready);
    assign load      = load_ok & grant_vld;

    always_comb begin
        o_ready = '0;
        if (load) begin
            o_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (grant_idx == SEL_W'(k)) begin
                sel_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Single output register entry; a load and a drain in the same cycle keep o_valid high.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_y     <= '0;
            o_ch    <= '0;
            o_valid <= 1'b0;
            last_q  <= SEL_W'(NUM_CH - 1);
        end else if (load) begin
            o_y     <= sel_data;
            o_ch    <= grant_idx;
            o_valid <= 1'b1;
            last_q  <= grant_idx;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cp_mux_n_to_1_arb.sv
// Directed bench for cp_mux_n_to_1_arb: driver pushes expected words, a monitor
// pops and compares them on each output handshake.
module tb_cp_mux_n_to_1_arb;

    localparam int unsigned DW  = 32;
    localparam int unsigned NC  = 4;
    localparam int unsigned SW  = 2;
    localparam int unsigned DW3 = 8;
    localparam int unsigned NC3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic              i_en = 1'b0;
    logic              i_mode = 1'b0;
    logic [SW-1:0]     i_sel = '0;
    logic [NC-1:0]     i_valid = '0;
    logic [NC*DW-1:0]  i_data = '0;
    logic [NC-1:0]     o_ready;
    logic [DW-1:0]     o_y;
    logic [SW-1:0]     o_ch;
    logic              o_valid;
    logic              i_ready = 1'b0;

    logic              en3 = 1'b0;
    logic              mode3 = 1'b0;
    logic [SW-1:0]     sel3 = '0;
    logic [NC3-1:0]    valid3 = '0;
    logic [NC3*DW3-1:0] data3 = '0;
    logic [NC3-1:0]    ready3;
    logic [DW3-1:0]    y3;
    logic [SW-1:0]     ch3;
    logic              ov3;
    logic              rdy3 = 1'b0;

    cp_mux_n_to_1_arb #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(i_en), .i_mode(i_mode), .i_sel(i_sel),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready), .o_y(o_y),
        .o_ch(o_ch), .o_valid(o_valid), .i_ready(i_ready)
    );

    cp_mux_n_to_1_arb #(.DATA_WIDTH(DW3), .NUM_CH(NC3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en3), .i_mode(mode3), .i_sel(sel3),
        .i_valid(valid3), .i_data(data3), .o_ready(ready3), .o_y(y3),
        .o_ch(ch3), .o_valid(ov3), .i_ready(rdy3)
    );

    typedef struct packed {
        logic [DW-1:0] y;
        logic [SW-1:0] ch;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  tag = 8'h00;
    logic [7:0]  held_tag;

    function automatic logic [DW-1:0] word(input int k, input logic [7:0] t);
        return {16'hA5A5, t, 8'(k)};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs, check the combinational ready and current o_valid,
    // and queue the word expected to be captured at the coming edge.
    task automatic drive(input logic rst, input logic en, input logic mode,
                         input logic [SW-1:0] sel, input logic [NC-1:0] vld,
                         input logic rdy, input logic [NC-1:0] exp_rdy,
                         input logic exp_ov, input string nm);
        @(posedge clk);
        #1;
        rst_n   = rst;
        i_en    = en;
        i_mode  = mode;
        i_sel   = sel;
        i_valid = vld;
        i_ready = rdy;
        for (int k = 0; k < int'(NC); k++) i_data[k*DW +: DW] = word(k, tag);
        #1;
        chk({nm, " o_ready"}, DW'(o_ready), DW'(exp_rdy));
        chk({nm, " o_valid"}, DW'(o_valid), DW'(exp_ov));
        for (int k = 0; k < int'(NC); k++) begin
            if (exp_rdy[k]) exp_q.push_back('{y: word(k, tag), ch: SW'(k)});
        end
        tag = tag + 8'd1;
    endtask

    // Every word the consumer accepts must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && o_valid === 1'b1 && i_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL mon_unexpected: got ch %0d y %0h, want no word", o_ch, o_y);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_y", o_y, mon_e.y);
                chk("mon_ch", DW'(o_ch), DW'(mon_e.ch));
            end
        end
    end

    initial begin
        // reset with all channels requesting
        drive(0, 1, 1, 0, 4'b1111, 1, 4'b0000, 0, "rst0");
        chk("rst0 o_y", o_y, '0);
        chk("rst0 o_ch", DW'(o_ch), '0);
        drive(0, 1, 1, 0, 4'b1111, 1, 4'b0000, 0, "rst1");
        chk("rst1 o_y", o_y, '0);
        chk("rst1 o_ch", DW'(o_ch), '0);

        // round-robin, all valid: 0,1,2,3,0
        drive(1, 1, 1, 0, 4'b1111, 1, 4'b0001, 0, "rr0");
        drive(1, 1, 1, 0, 4'b1111, 1, 4'b0010, 1, "rr1");
        drive(1, 1, 1, 0, 4'b1111, 1, 4'b0100, 1, "rr2");
        drive(1, 1, 1, 0, 4'b1111, 1, 4'b1000, 1, "rr3");
        drive(1, 1, 1, 0, 4'b1111, 1, 4'b0001, 1, "rr4");
        // round-robin, sparse: 1,3,1,3
        drive(1, 1, 1, 0, 4'b1010, 1, 4'b0010, 1, "rrs0");
        drive(1, 1, 1, 0, 4'b1010, 1, 4'b1000, 1, "rrs1");
        drive(1, 1, 1, 0, 4'b1010, 1, 4'b0010, 1, "rrs2");
        drive(1, 1, 1, 0, 4'b1010, 1, 4'b1000, 1, "rrs3");

        // fixed select
        drive(1, 1, 0, 2, 4'b1111, 1, 4'b0100, 1, "fix2");
        drive(1, 1, 0, 2, 4'b1011, 1, 4'b0000, 1, "fix2_novld");
        drive(1, 1, 0, 2, 4'b1011, 1, 4'b0000, 0, "fix2_drained");

        // backpressure: grant ch3 (last=2), then stall three cycles
        drive(1, 1, 1, 0, 4'b1111, 1, 4'b1000, 0, "bp_load");
        held_tag = tag - 8'd1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 4'b1111, 0, 4'b0000, 1, "bp_stall");
            chk("bp_hold_ch", DW'(o_ch), DW'(3));
            chk("bp_hold_y", o_y, word(3, held_tag));
        end
        drive(1, 1, 1, 0, 4'b1111, 1, 4'b0001, 1, "bp_release");

        // enable low: held word drains, nothing new granted
        drive(1, 0, 1, 0, 4'b1111, 1, 4'b0000, 1, "en_off0");
        drive(1, 0, 1, 0, 4'b1111, 1, 4'b0000, 0, "en_off1");
        drive(1, 1, 1, 0, 4'b1111, 1, 4'b0010, 0, "en_on");

        // mode switch: RR ch3, fixed ch1, RR resumes at ch2
        drive(1, 1, 1, 0, 4'b1000, 1, 4'b1000, 1, "ms_rr3");
        drive(1, 1, 0, 1, 4'b1111, 1, 4'b0010, 1, "ms_fix1");
        drive(1, 1, 1, 0, 4'b1111, 1, 4'b0100, 1, "ms_rr2");

        drive(1, 1, 1, 0, 4'b0000, 1, 4'b0000, 1, "tail0");
        drive(1, 1, 1, 0, 4'b0000, 1, 4'b0000, 0, "tail1");

        // three-channel instance: out-of-range select never grants
        @(posedge clk);
        #1;
        en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3; valid3 = 3'b111; rdy3 = 1'b1;
        data3 = {8'h22, 8'h11, 8'h00};
        #1;
        chk("n3_sel3 o_ready", DW'(ready3), '0);
        @(posedge clk);
        #1;
        chk("n3_sel3 o_valid", DW'(ov3), '0);
        sel3 = 2'd2;
        #1;
        chk("n3_sel2 o_ready", DW'(ready3), DW'(3'b100));
        @(posedge clk);
        #1;
        valid3 = '0;
        chk("n3_sel2 o_valid", DW'(ov3), DW'(1));
        chk("n3_sel2 o_y", DW'(y3), DW'(8'h22));
        chk("n3_sel2 o_ch", DW'(ch3), DW'(2));

        repeat (2) @(posedge clk);
        chk("queue_empty", DW'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
